// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Geometry is fixed to a 4x4 membrane pad; the row FSM walks the rows in order.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NKEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    ROW0,
    ROW1,
    ROW2,
    ROW3
  } row_state_t;

  // Bit position of a key in the flattened key image.
  function automatic int key_idx(input int row, input int col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Both flops reset to RST_VAL so the output never shows a spurious value out of reset.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples the columns,
// and debounces the whole 16-key image before publishing it with a new-press strobe.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [ROWS-1:0]  row_o,
  input  logic [COLS-1:0]  col_i,
  output logic [NKEYS-1:0] key,
  output logic             press
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ROWS-1:0]  ROW_ONE  = ROWS'(1);

  // ---------------------------------------------------------------------------
  // Column synchronizer; released columns read high, so reset to all-ones.
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_sync;
  logic [COLS-1:0] col_hit;

  sync2 #(
    .WIDTH  (COLS),
    .RST_VAL({COLS{1'b1}})
  ) u_col_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (col_i),
    .q    (col_sync)
  );

  assign col_hit = ~col_sync;

  // ---------------------------------------------------------------------------
  // Row FSM
  // ---------------------------------------------------------------------------
  row_state_t       state;
  row_state_t       next_state;
  logic [ROWS-1:0]  row_next;
  logic [DIV_W-1:0] div;
  logic             sample;

  assign sample = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROW0;
      row_o <= 4'b1110;
    end else begin
      state <= next_state;
      // Registered so the row drive never glitches while the state decodes.
      row_o <= row_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (sample) begin
      unique case (state)
        ROW0: next_state = ROW1;
        ROW1: next_state = ROW2;
        ROW2: next_state = ROW3;
        ROW3: next_state = ROW0;
        default: next_state = ROW0;
      endcase
    end
    row_next = ~(ROW_ONE << next_state);
  end

  // ---------------------------------------------------------------------------
  // Frame assembly and debounce
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] frame;
  logic [NKEYS-1:0] frame_now;
  logic [NKEYS-1:0] last_frame;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_end;
  logic             commit;

  // Frame image with the row being sampled this cycle already merged in, so the
  // ROW3 columns take part in the end-of-frame comparison.
  always_comb begin
    frame_now = frame;
    frame_now[key_idx(int'(state), 0) +: COLS] = col_hit;
  end

  always_comb begin
    if (frame_now != last_frame) begin
      cnt_next = CNT_ONE;
    end else if (stable_cnt == CNT_MAX) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = stable_cnt + 1'b1;
    end
  end

  assign frame_end = sample && (state == ROW3);
  assign commit    = frame_end && (cnt_next == CNT_MAX);

  // NOTE: all of this is control state, so every register is reset; an
  // unreset frame would leak a stale partial image into the first comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      frame      <= '0;
      last_frame <= '0;
      stable_cnt <= '0;
      key        <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample) begin
        div   <= '0;
        frame <= frame_now;
      end else begin
        div <= div + 1'b1;
      end
      if (frame_end) begin
        last_frame <= frame_now;
        stable_cnt <= cnt_next;
      end
      if (commit) begin
        key   <= frame_now;
        // Only newly set bits count; releases and re-commits of a held image are silent.
        press <= |(frame_now & ~key);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives the columns, expected
// key/press events (tagged with their frame number) are queued and matched on output.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [15:0] key;
  logic        press;

  logic [15:0] pressed = '0;
  logic        force_cols = 1'b1;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int          frame;
    logic [15:0] key;
    logic        press;
  } evt_t;

  evt_t exp_q[$];

  int          frame_no = 0;
  logic [3:0]  prev_row = 4'b1110;
  logic [15:0] prev_key = '0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .row_o(row_o),
    .col_i(col_i),
    .key  (key),
    .press(press)
  );

  // Passive keypad: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_i = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_o[r] && pressed[r*4 + c]) col_i[c] = 1'b0;
      end
    end
    if (force_cols) col_i = 4'b0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_evt(input int frame, input logic [15:0] k, input logic p);
    evt_t e;
    e.frame = frame;
    e.key   = k;
    e.press = p;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the first posedge at which frame_no has reached n.
  task automatic wait_frame(input int n);
    int t;
    t = 0;
    while (frame_no < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (frame_no < n) check("wait_frame", frame_no, n);
    #1;
  endtask

  // Monitor: counts completed frames and matches every key change or press pulse.
  always @(negedge clk) begin : monitor
    evt_t e;
    if (!rst_n) begin
      frame_no = 0;
      prev_row = 4'b1110;
      prev_key = '0;
    end else begin
      if (prev_row == 4'b0111 && row_o == 4'b1110) frame_no++;
      prev_row = row_o;
      if (key !== prev_key || press !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_key", key, prev_key);
          check("spurious_press", press, 0);
        end else begin
          e = exp_q.pop_front();
          check("evt_frame", frame_no, e.frame);
          check("evt_key", key, e.key);
          check("evt_press", press, e.press);
        end
      end
      prev_key = key;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] exp_row;
    int t;

    // Reset with all columns shorted low: outputs must still show reset values.
    repeat (3) @(negedge clk);
    check("rst_row", row_o, 4'b1110);
    check("rst_key", key, 16'h0000);
    check("rst_press", press, 0);

    @(negedge clk);
    force_cols = 1'b0;
    rst_n      = 1'b1;

    // Row drive steps every 4 cycles through the four rows.
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((j / 4) % 4));
      check("row_step", row_o, exp_row);
    end

    // Single press of key 5, held for 10 more frames, then released.
    wait_frame(2);
    pressed = 16'h0020;
    push_evt(5, 16'h0020, 1'b1);
    wait_frame(15);
    pressed = 16'h0000;
    push_evt(18, 16'h0000, 1'b0);

    // Key 15 bounces frame-to-frame, then settles closed.
    for (int i = 0; i < 5; i++) begin
      wait_frame(20 + i);
      pressed[15] = (i % 2 == 0);
    end
    push_evt(27, 16'h8000, 1'b1);
    wait_frame(28);
    pressed = 16'h0000;
    push_evt(31, 16'h0000, 1'b0);

    // Multi-key: key 0 held, then key 10 added.
    wait_frame(33);
    pressed = 16'h0001;
    push_evt(36, 16'h0001, 1'b1);
    wait_frame(38);
    pressed = 16'h0401;
    push_evt(41, 16'h0401, 1'b1);

    // Swap to key 3 alone: new bit appears while the others release.
    wait_frame(43);
    pressed = 16'h0008;
    push_evt(46, 16'h0008, 1'b1);

    // Reset in the middle of ROW2 with key 3 still held.
    wait_frame(48);
    t = 0;
    while (row_o !== 4'b1011 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("row2_reached", row_o, 4'b1011);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_row", row_o, 4'b1110);
    check("midrst_key", key, 16'h0000);
    check("midrst_press", press, 0);
    push_evt(3, 16'h0008, 1'b1);
    repeat (3) @(negedge clk);
    check("midrst_hold_key", key, 16'h0000);
    rst_n = 1'b1;

    wait_frame(5);
    check("events_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
